dot64_vec_loader: RTL and testbench



---
 rtl/dot64_vec_loader.sv | 110 +++++++++++
 tb/tb_dot64_vec_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot64_vec_loader.sv
// Stream-to-vector loader: collects (a,b) element pairs into two zero-padded
// N-element vectors and holds them frozen for the downstream dot-product stage.
module dot64_vec_loader #(
   parameter int N = 64,
   parameter int W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [W-1:0]        in_a,
   input  logic signed [W-1:0]        in_b,
   input  logic                       in_last,
   output logic signed [W-1:0]        vec_a [0:N-1],
   output logic signed [W-1:0]        vec_b [0:N-1],
   output logic [$clog2(N+1)-1:0]     vec_len,
   output logic                       vec_valid,
   input  logic                       vec_ready
);

   localparam int IW = $clog2(N);
   localparam int LW = $clog2(N+1);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [IW-1:0]   idx_r;
   logic            accept_s;
   logic            done_s;
   logic            release_s;

   assign accept_s  = in_valid && (state_r == FILL);
   assign done_s    = accept_s && (in_last || (idx_r == IW'(N-1)));
   assign release_s = (state_r == HOLD) && vec_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= FILL;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FILL:    state_nxt_s = done_s ? HOLD : FILL;
         HOLD:    state_nxt_s = release_s ? FILL : HOLD;
         default: state_nxt_s = FILL;
      endcase
   end

   // Handshake outputs depend on the state register only
   always_comb begin
      in_ready  = 1'b1;
      vec_valid = 1'b0;
      case (state_r)
         FILL: begin
            in_ready  = 1'b1;
            vec_valid = 1'b0;
         end
         HOLD: begin
            in_ready  = 1'b0;
            vec_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b1;
            vec_valid = 1'b0;
         end
      endcase
   end

   // Vector storage, index and length; clearing on release provides the zero padding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            vec_a[i] <= {W{1'b0}};
            vec_b[i] <= {W{1'b0}};
         end
         idx_r   <= {IW{1'b0}};
         vec_len <= {LW{1'b0}};
      end else if (release_s) begin
         for (int i = 0; i < N; i++) begin
            vec_a[i] <= {W{1'b0}};
            vec_b[i] <= {W{1'b0}};
         end
         idx_r   <= {IW{1'b0}};
         vec_len <= {LW{1'b0}};
      end else if (accept_s) begin
         vec_a[idx_r] <= in_a;
         vec_b[idx_r] <= in_b;
         if (done_s) begin
            // idx is left in place at completion so it never wraps past N-1
            vec_len <= LW'(idx_r) + LW'(1);
         end else begin
            idx_r <= idx_r + IW'(1);
         end
      end else begin
         idx_r   <= idx_r;
         vec_len <= vec_len;
      end
   end

endmodule

// File: tb/tb_dot64_vec_loader.sv
// Directed bench for dot64_vec_loader: a driver pushes expected vectors into a
// scoreboard queue and a negedge monitor checks each vector as vec_valid rises.
module tb_dot64_vec_loader;

   localparam int N = 64;
   localparam int W = 16;

   typedef struct packed {
      logic [6:0]               len;
      logic [N-1:0][W-1:0]      a;
      logic [N-1:0][W-1:0]      b;
      logic signed [63:0]       dot;
   } exp_t;

   logic                  clk;
   logic                  rst_n;
   logic                  in_valid;
   logic                  in_ready;
   logic signed [W-1:0]   in_a;
   logic signed [W-1:0]   in_b;
   logic                  in_last;
   logic signed [W-1:0]   vec_a [0:N-1];
   logic signed [W-1:0]   vec_b [0:N-1];
   logic [6:0]            vec_len;
   logic                  vec_valid;
   logic                  vec_ready;

   int checks   = 0;
   int failures = 0;

   exp_t                  sb_q [$];
   logic signed [W-1:0]   sa [0:N-1];
   logic signed [W-1:0]   sbv [0:N-1];

   dot64_vec_loader #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .vec_a     (vec_a),
      .vec_b     (vec_b),
      .vec_len   (vec_len),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Entries 0..n-1 must equal the stimulus arrays, the rest zero
   task automatic chk_model(input string name, input int n);
      int bad = 0;
      for (int i = 0; i < N; i++) begin
         if (i < n) begin
            if (vec_a[i] !== sa[i] || vec_b[i] !== sbv[i]) bad++;
         end else begin
            if (vec_a[i] !== 16'sd0 || vec_b[i] !== 16'sd0) bad++;
         end
      end
      chk(name, bad, 0);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Push the expectation, then stream n pairs back to back
   task automatic feed(input int n, input bit use_last, input longint exp_dot);
      exp_t e;
      e = '0;
      e.len = 7'(n);
      for (int i = 0; i < n; i++) begin
         e.a[i] = sa[i];
         e.b[i] = sbv[i];
      end
      e.dot = exp_dot;
      sb_q.push_back(e);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_a     = sa[i];
         in_b     = sbv[i];
         in_last  = use_last && (i == n - 1);
         if (i == n - 1) chk("valid_before_last", vec_valid, 0);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("valid_after_last", vec_valid, 1);
      chk("ready_in_hold", in_ready, 0);
   endtask

   task automatic release_vec;
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      chk("ready_after_release", in_ready, 1);
      chk_model("cleared_after_release", 0);
   endtask

   // Scoreboard monitor
   logic   prev_valid = 1'b0;
   exp_t   m_e;
   longint m_dot;
   int     m_bad;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (vec_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_vector actual=1 expected=0");
            end else begin
               m_e   = sb_q.pop_front();
               m_dot = 0;
               m_bad = 0;
               for (int i = 0; i < N; i++) begin
                  m_dot += longint'(vec_a[i]) * longint'(vec_b[i]);
                  if (vec_a[i] !== m_e.a[i] || vec_b[i] !== m_e.b[i]) m_bad++;
               end
               chk("sb_vec_len", vec_len, m_e.len);
               chk("sb_entries_bad", m_bad, 0);
               chk("sb_dot", m_dot, m_e.dot);
            end
         end
         prev_valid = vec_valid;
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = 16'sd0;
      in_b      = 16'sd0;
      in_last   = 1'b0;
      vec_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      chk("reset_in_ready", in_ready, 1);
      chk("reset_vec_valid", vec_valid, 0);
      chk("reset_vec_len", vec_len, 0);
      chk_model("reset_entries", 0);

      // vec_ready pulse while filling is ignored
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      chk("fill_ready_ignored", vec_valid, 0);

      // Full vector: a=i+1, b=2 -> 4160
      for (int i = 0; i < N; i++) begin
         sa[i]  = 16'(i + 1);
         sbv[i] = 16'sd2;
      end
      feed(64, 1'b1, 64'sd4160);
      chk("full_a63", vec_a[63], 64);
      release_vec();

      // Short vector -> 9957
      for (int i = 0; i < N; i++) begin
         sa[i]  = 16'sd0;
         sbv[i] = 16'sd0;
      end
      sa[0] = 16'sd5;    sbv[0] = -16'sd3;
      sa[1] = -16'sd7;   sbv[1] = 16'sd4;
      sa[2] = 16'sd100;  sbv[2] = 16'sd100;
      feed(3, 1'b1, 64'sd9957);
      chk("short_len", vec_len, 3);
      release_vec();

      // Forced completion without in_last: a=i-32, b=3 -> 3*(-32) = -96
      for (int i = 0; i < N; i++) begin
         sa[i]  = 16'(i - 32);
         sbv[i] = 16'sd3;
      end
      feed(64, 1'b0, -64'sd96);
      chk("forced_len", vec_len, 64);

      // Backpressure with changing input data
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_a     = 16'(1000 + k);
         in_b     = 16'(-1000 - k);
         tick();
         chk("bp_in_ready", in_ready, 0);
         chk("bp_vec_len", vec_len, 64);
         chk_model("bp_entries", 64);
      end
      // Handshake with an element still presented: it must not be taken
      in_a = 16'sd999;
      in_b = 16'sd999;
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      in_valid  = 1'b0;
      chk("bp_release_ready", in_ready, 1);
      chk("bp_release_len", vec_len, 0);
      chk_model("bp_release_zero", 0);

      // Next element lands in index 0 (short vector, checked by scoreboard)
      for (int i = 0; i < N; i++) begin
         sa[i]  = 16'sd0;
         sbv[i] = 16'sd0;
      end
      sa[0] = 16'sd12; sbv[0] = 16'sd10;
      feed(1, 1'b1, 64'sd120);
      release_vec();

      // Extremes
      for (int i = 0; i < N; i++) begin
         sa[i]  = 16'sh8000;
         sbv[i] = 16'sh8000;
      end
      feed(64, 1'b1, 64'sd68719476736);
      chk("ext_a0_raw", {16'h0, vec_a[0]}, 32'h0000_8000);
      release_vec();

      // Reset mid-fill after 20 accepts
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_a     = 16'(i + 100);
         in_b     = 16'(i + 200);
         tick();
      end
      in_valid = 1'b0;
      chk("midfill_a19", vec_a[19], 119);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_a0", vec_a[0], 0);
      chk("async_rst_b19", vec_b[19], 0);
      chk("async_rst_ready", in_ready, 1);
      chk("async_rst_valid", vec_valid, 0);
      #1;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < N; i++) begin
         sa[i]  = 16'sd0;
         sbv[i] = 16'sd0;
      end
      sa[0] = 16'sd11;  sbv[0] = -16'sd2;
      sa[1] = -16'sd6;  sbv[1] = 16'sd7;
      feed(2, 1'b1, -64'sd64);
      chk("post_rst_len", vec_len, 2);
      chk_model("post_rst_entries", 2);
      release_vec();

      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=1 expected=0");
      $fatal(1, "timeout");
   end

endmodule
